flappy_bird_control_button_in: RTL and testbench

FLAPPY_BIRD_CONTROL_BUTTON_IN -- requirements
Module: flappy_bird_control_button_in

---
 rtl/flappy_bird_control_button_in_if.sv | 28 ++
 rtl/flappy_bird_control_button_in.sv | 103 ++++++++++
 tb/tb_flappy_bird_control_button_in.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/flappy_bird_control_button_in_if.sv
// Avalon-MM slave bundle for the button input peripheral.
// Carries the word-addressed register bus plus the level interrupt.
interface flappy_bird_control_button_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/flappy_bird_control_button_in.sv
// Button input port: sync, optional debounce, rising-edge capture, irq.
// Define FLAPPY_BIRD_CONTROL_BUTTON_IN_DEBOUNCE_EN to add the debounce filter.
module flappy_bird_control_button_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    flappy_bird_control_button_in_if.slave bus
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_mux;
    logic [31:0]      readdata_q;
    logic             wr;
    logic             unused_wdata;

    assign wr           = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef FLAPPY_BIRD_CONTROL_BUTTON_IN_DEBOUNCE_EN
    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] cnt [WIDTH];

    // Any cycle where sync2 matches level restarts the stability window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= CNT_MAX) begin
                    level[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) level <= '0;
        else          level <= sync2;
    end
`endif

    assign rise = level & ~level_d;

    always_comb begin
        clr    = '0;
        rd_mux = '0;
        if (wr && bus.address == 2'd3) clr = wdata;
        unique case (bus.address)
            2'd0: rd_mux[WIDTH-1:0] = level;
            2'd1: rd_mux = '0;
            2'd2: rd_mux[WIDTH-1:0] = irq_mask;
            2'd3: rd_mux[WIDTH-1:0] = edge_capture;
        endcase
    end

    // A new edge overrides a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_d      <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata_q   <= '0;
        end else begin
            level_d      <= level;
            edge_capture <= (edge_capture & ~clr) | rise;
            readdata_q   <= rd_mux;
            if (wr && bus.address == 2'd2) irq_mask <= wdata;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_flappy_bird_control_button_in.sv
// Bench for flappy_bird_control_button_in: vector table, reset and
// randomized checks against a sample-history reference model.
module tb_flappy_bird_control_button_in;

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wr_n;
        logic [31:0] wdata;
        logic [3:0]  inp;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] in_port;
    int         errors = 0;
    int         checks = 0;

    flappy_bird_control_button_in_if bus ();

    flappy_bird_control_button_in #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .in_port(in_port),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Model: hist[n] is the in_port value sampled n+1 edges ago.
    logic [3:0]  hist [4];
    logic [3:0]  m_ec;
    logic [3:0]  m_mask;
    logic [31:0] m_rd;
    logic        m_irq;
    vec_t        tbl [$];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) hist[i] = '0;
        m_ec   = '0;
        m_mask = '0;
        m_rd   = '0;
        m_irq  = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] lvl;
        logic [3:0] rs;
        logic [3:0] cl;
        logic       w;
        lvl = hist[2];
        rs  = hist[2] & ~hist[3];
        w   = bus.chipselect && !bus.write_n;
        cl  = (w && bus.address == 2'd3) ? bus.writedata[3:0] : 4'd0;
        case (bus.address)
            2'd0:    m_rd = {28'd0, lvl};
            2'd2:    m_rd = {28'd0, m_mask};
            2'd3:    m_rd = {28'd0, m_ec};
            default: m_rd = 32'd0;
        endcase
        m_ec = (m_ec & ~cl) | rs;
        if (w && bus.address == 2'd2) m_mask = bus.writedata[3:0];
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = in_port;
        m_irq = |(m_ec & m_mask);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        model_edge();
        tick();
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] a, input logic cs,
                         input logic wn, input logic [31:0] wd,
                         input logic [3:0] inp);
        bus.address    = a;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.writedata  = wd;
        in_port        = inp;
    endtask

    task automatic put(input logic [1:0] a, input logic cs,
                       input logic wn, input logic [31:0] wd,
                       input logic [3:0] inp, input logic [31:0] rd,
                       input logic irq);
        tbl.push_back('{a, cs, wn, wd, inp, rd, irq});
    endtask

    initial begin
        reset_n = 1'b0;
        drive(2'd0, 1'b0, 1'b1, 32'd0, 4'd0);
        model_reset();
        repeat (3) tick();
        check("reset_rd", bus.readdata, 32'd0);
        check("reset_irq", {31'd0, bus.irq}, 32'd0);
        reset_n = 1'b1;

`ifndef FLAPPY_BIRD_CONTROL_BUTTON_IN_DEBOUNCE_EN
        for (int i = 0; i < 4; i++) put(3, 0, 1, 0, 1, 0, 0);
        put(3, 0, 1, 0, 1, 1, 0);
        put(0, 0, 1, 0, 1, 1, 0);
        put(1, 1, 0, 32'hFFFF_FFFF, 1, 0, 0);
        put(0, 1, 0, 32'hFFFF_FFFF, 1, 1, 0);
        put(2, 0, 1, 0, 1, 0, 0);
        put(2, 1, 0, 32'hFFFF_FFF1, 1, 0, 1);
        put(2, 0, 1, 0, 1, 1, 1);
        put(3, 1, 0, 1, 1, 1, 0);
        put(3, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) put(3, 0, 1, 0, 3, 0, 0);
        put(3, 1, 0, 2, 3, 0, 0);
        put(3, 0, 1, 0, 3, 2, 0);
        put(3, 1, 0, 32'hF, 3, 2, 0);
        put(3, 0, 1, 0, 3, 0, 0);
        for (int i = 0; i < 3; i++) put(3, 0, 1, 0, 2, 0, 0);
        for (int i = 0; i < 3; i++) put(3, 0, 1, 0, 3, 0, 0);
        put(3, 0, 1, 0, 3, 0, 1);
        put(3, 0, 1, 0, 3, 1, 1);
        put(1, 1, 0, 32'hFFFF_FFFF, 3, 0, 1);
        put(0, 1, 0, 32'hFFFF_FFFF, 3, 3, 1);
        put(2, 0, 1, 0, 3, 1, 1);
        put(3, 0, 1, 0, 3, 1, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].addr, tbl[i].cs, tbl[i].wr_n,
                  tbl[i].wdata, tbl[i].inp);
            step();
            check($sformatf("vec%0d_rd", i), bus.readdata,
                  tbl[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'd0, bus.irq},
                  {31'd0, tbl[i].exp_irq});
        end

        // Build up captures = 0xF with mask = 0xF, then reset mid-run.
        drive(2'd3, 1'b1, 1'b0, 32'hF, 4'd0);
        step();
        drive(2'd2, 1'b1, 1'b0, 32'hF, 4'd0);
        step();
        drive(2'd3, 1'b1, 1'b0, 32'hF, 4'd0);
        repeat (4) step();
        drive(2'd3, 1'b0, 1'b1, 32'd0, 4'hF);
        repeat (5) step();
        check("pre_reset_ec", bus.readdata, 32'hF);
        check("pre_reset_irq", {31'd0, bus.irq}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_rd", bus.readdata, 32'd0);
        check("async_rst_irq", {31'd0, bus.irq}, 32'd0);
        tick();
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("post_rst%0d_rd", i), bus.readdata, m_rd);
        end
        check("post_rst_ec", bus.readdata, 32'hF);
        check("post_rst_irq", {31'd0, bus.irq}, 32'd0);
        drive(2'd2, 1'b0, 1'b1, 32'd0, 4'hF);
        step();
        check("post_rst_mask", bus.readdata, 32'd0);

        for (int n = 0; n < 400; n++) begin
            logic [3:0] inp;
            inp = ($urandom_range(3) == 0) ? 4'($urandom) : in_port;
            drive(2'($urandom), 1'($urandom),
                  ($urandom_range(3) != 0), $urandom, inp);
            step();
            check("rand_rd", bus.readdata, m_rd);
            check("rand_irq", {31'd0, bus.irq}, {31'd0, m_irq});
        end
`else
        drive(2'd3, 1'b0, 1'b1, 32'd0, 4'd0);
        for (int c = 0; c < 100; c++) begin
            in_port = {3'd0, 1'((c / 5) % 2)};
            tick();
            check("bounce_ec", bus.readdata, 32'd0);
        end
        in_port = 4'd1;
        repeat (20) tick();
        check("held_ec", bus.readdata, 32'd1);
        bus.address = 2'd0;
        tick();
        check("held_level", bus.readdata, 32'd1);
        bus.address = 2'd3;
        repeat (3) tick();
        check("held_ec_once", bus.readdata, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
